powlib_ipinit: RTL
==================

POWLIB_IPINIT -- requirements
Module: powlib_ipinit

Interface
REQ-001 Parameter ID, "IPINIT", string identifier used in debug messages.
REQ-002 Parameter EAR, 0, enable asynchronous reset on internal flip-flops; this block's reset ports remain synchronous.
REQ-003 Parameter EDBG, 0, when 1 the block displays each issued request and each received response, prefixed with ID.
REQ-004 Parameter B_BPD, 4, bytes per data word; B_DW=8*B_BPD, B_BEW=B_BPD, B_WW=POWLIB_OPW+B_BEW+B_DW.
REQ-005 Parameter B_AW, 8*B_BPD, address width; B_AW SHALL be <= B_DW, else the block SHALL $display an error and $finish at elaboration.
REQ-006 Parameter MAX_OUT, 4, maximum outstanding reads (1..16); it also sets the response buffer depth.
REQ-007 Parameter RET_ADDR, 0, return address (B_AW bits) placed in the data field of every read.
REQ-008 clk in 1 -- single clock; rst in 1 -- reset, synchronous and active-high.
REQ-009 reqaddr in B_AW; reqdata in B_DW; reqbe in B_BEW; reqop in POWLIB_OPW; reqvld in 1; reqrdy out 1 -- command port.
REQ-010 wraddr out B_AW; wrdata out B_WW; wrvld out 1; wrrdy in 1 -- bus request output.
REQ-011 rdaddr in B_AW; rddata in B_WW; rdvld in 1; rdrdy out 1 -- bus response input.
REQ-012 rspdata out B_DW; rspvld out 1; rsprdy in 1 -- read-data output.
REQ-013 outcnt out clog2(MAX_OUT+1) -- outstanding read count; err out 1 -- sticky protocol error.

Function
REQ-014 Packed word layout SHALL be: data in bits [B_DW-1:0], byte enables above the data, op in the top POWLIB_OPW bits.
REQ-015 Handshake: a transfer occurs only when vld and rdy are both high on a rising clk edge; vld with its payload SHALL hold until the transfer.
REQ-016 Command accepted at edge N SHALL appear registered on the bus port at N+1 (wrvld=1, wraddr=reqaddr).
- The output register is one entry.
- reqrdy = (!wrvld || wrrdy) && credit_ok.
REQ-017 POWLIB_OP_WRITE commands SHALL pack {WRITE, reqbe, reqdata}; credit_ok=1 for writes.
REQ-018 POWLIB_OP_READ commands SHALL pack:
- data = RET_ADDR zero-extended to B_DW;
- be = all ones;
- op = READ;
- credit_ok = (outcnt < MAX_OUT).
REQ-019 Any other reqop SHALL be accepted and dropped (no bus output) and SHALL set err.
REQ-020 outcnt SHALL increment when a read is accepted on the command port, and decrement when rspvld && rsprdy; on the same edge it SHALL be unchanged.
REQ-021 Response buffer SHALL be a FIFO of depth MAX_OUT; rdrdy SHALL be tied to 1.
- Responses are returned in issue order.
- Credits guarantee the FIFO cannot overflow.
REQ-022 Valid response checks (all must hold):
- rdaddr == RET_ADDR;
- unpacked op == POWLIB_OP_WRITE;
- buffered-plus-pending reads < outcnt.
A valid response SHALL push its unpacked data. An invalid one SHALL be dropped and SHALL set err.
REQ-023 rspvld SHALL rise no earlier than the edge after the response transfer; rspdata = FIFO head.
REQ-024 err SHALL remain 1 until rst.

Reset
REQ-025 On rst=1 at an edge, the block SHALL drive wrvld=0, rspvld=0, outcnt=0 and err=0, and SHALL empty the response FIFO; reqrdy SHALL be 0 while rst=1.
REQ-026 Reset mid-operation SHALL discard in-flight requests and buffered data; responses arriving after reset are unsolicited and SHALL be dropped and set err per REQ-022.

Verification
REQ-027 Write: reqop=WRITE, reqaddr=0x10, reqdata=0xA5A5A5A5, reqbe=0xF -> next cycle wrvld=1, wraddr=0x10, wrdata={WRITE,0xF,0xA5A5A5A5}; outcnt stays 0.
REQ-028 Read round trip with RET_ADDR=0x40: read addr 0x08 -> wrdata data field = 0x40 and outcnt=1; respond rdaddr=0x40, data 0x12345678 -> rspdata=0x12345678 with rspvld=1, then outcnt=0 after rsprdy.
REQ-029 Credit limit with MAX_OUT=4 and no responses: issue 5 reads -> 4 accepted, reqrdy=0 on the 5th; one response plus consumption -> 5th accepted on the following edge.
REQ-030 Backpressure: wrrdy=0 for 10 cycles with 3 queued writes -> wrdata holds the first write and reqrdy=0; no loss or duplication after release.
REQ-031 Errors: a response with rdaddr=0x44 (RET_ADDR=0x40), or any response when outcnt=0 -> dropped, err=1 and held until rst.
REQ-032 Reset with 2 reads outstanding -> outcnt=0, rspvld=0, err=0; a late response then arrives -> dropped, err=1.

Source files
------------

// File: rtl/powlib_ipinit.sv
// Bus initiator: turns command-port requests into packed bus words and collects
// read responses, in issue order, through a credit-limited response FIFO.
module powlib_ipinit #(
  parameter string ID                 = "IPINIT",
  parameter int    EAR                = 0,
  parameter int    EDBG               = 0,
  parameter int    B_BPD              = 4,
  parameter int    B_AW               = 8*B_BPD,
  parameter int    MAX_OUT            = 4,
  parameter logic [B_AW-1:0] RET_ADDR = '0,
  localparam int   OPW                = 4,
  localparam int   B_DW               = 8*B_BPD,
  localparam int   B_BEW              = B_BPD,
  localparam int   B_WW               = OPW+B_BEW+B_DW,
  localparam int   CW                 = $clog2(MAX_OUT+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [B_AW-1:0]  reqaddr,
  input  logic [B_DW-1:0]  reqdata,
  input  logic [B_BEW-1:0] reqbe,
  input  logic [OPW-1:0]   reqop,
  input  logic             reqvld,
  output logic             reqrdy,
  output logic [B_AW-1:0]  wraddr,
  output logic [B_WW-1:0]  wrdata,
  output logic             wrvld,
  input  logic             wrrdy,
  input  logic [B_AW-1:0]  rdaddr,
  input  logic [B_WW-1:0]  rddata,
  input  logic             rdvld,
  output logic             rdrdy,
  output logic [B_DW-1:0]  rspdata,
  output logic             rspvld,
  input  logic             rsprdy,
  output logic [CW-1:0]    outcnt,
  output logic             err
);

  localparam logic [OPW-1:0] OP_WRITE = 4'd0;
  localparam logic [OPW-1:0] OP_READ  = 4'd1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  generate
    if (B_AW > B_DW) begin : g_aw_chk
      $fatal(1, "%s: B_AW (%0d) must not exceed B_DW (%0d)", ID, B_AW, B_DW);
    end
    if (MAX_OUT < 1 || MAX_OUT > 16 || EAR < 0 || EAR > 1 || EDBG < 0 || EDBG > 1) begin : g_par_chk
      $fatal(1, "%s: MAX_OUT must be 1..16, EAR and EDBG must be 0 or 1", ID);
    end
  endgenerate

  function automatic logic [B_WW-1:0] pack_cmd(input logic rd, input logic [B_BEW-1:0] be,
                                               input logic [B_DW-1:0] data);
    if (rd) return {OP_READ, {B_BEW{1'b1}}, B_DW'(RET_ADDR)};
    return {OP_WRITE, be, data};
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT-1)) ? '0 : p + 1'b1;
  endfunction

  logic              is_wr, is_rd, credit_ok, accept, load, pop, push, rsp_ok;
  logic [CW-1:0]     fifo_cnt;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [B_DW-1:0]   fifo_mem [MAX_OUT];
  logic [B_BEW-1:0]  unused_be;

  assign is_wr     = (reqop == OP_WRITE);
  assign is_rd     = (reqop == OP_READ);
  assign credit_ok = !is_rd || (outcnt < CW'(MAX_OUT));
  assign reqrdy    = !rst && (!wrvld || wrrdy) && credit_ok;
  assign accept    = reqvld && reqrdy;
  assign load      = accept && (is_wr || is_rd);
  assign pop       = rspvld && rsprdy;
  assign rdrdy     = 1'b1;
  // A response is only believable if some issued read is still waiting for data.
  assign rsp_ok    = (rdaddr == RET_ADDR) && (rddata[B_WW-1 -: OPW] == OP_WRITE) &&
                     (fifo_cnt < outcnt);
  assign push      = rdvld && rsp_ok;
  assign rspvld    = (fifo_cnt != '0);
  assign rspdata   = fifo_mem[rd_ptr];
  assign unused_be = rddata[B_DW +: B_BEW];

  // control stage: bus output valid, credits, FIFO occupancy, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      wrvld    <= 1'b0;
      outcnt   <= '0;
      err      <= 1'b0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (load)       wrvld <= 1'b1;
      else if (wrrdy) wrvld <= 1'b0;

      case ({accept && is_rd, pop})
        2'b10:   outcnt <= outcnt + 1'b1;
        2'b01:   outcnt <= outcnt - 1'b1;
        default: outcnt <= outcnt;
      endcase

      if ((accept && !is_wr && !is_rd) || (rdvld && !rsp_ok)) err <= 1'b1;

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  // data stage: bus output word and FIFO storage (no reset needed)
  always_ff @(posedge clk) begin
    if (load) begin
      wraddr <= reqaddr;
      wrdata <= pack_cmd(is_rd, reqbe, reqdata);
    end
    if (push) fifo_mem[wr_ptr] <= rddata[B_DW-1:0];
  end

endmodule
